// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crc_pkg
//  Description : Shared definitions for the CRC frame arbiter: CRC width,
//                default seed and the sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package crc_pkg;

    localparam int CRC_W = 16;
    localparam logic [CRC_W-1:0] CRC_SEED_DEFAULT = 16'hFFFF;

    // IDLE: arbitrate, DATA: forward granted frame, CRC: append CRC word
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;

endpackage : crc_pkg
`default_nettype wire

// File: rtl/crc_frame_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : crc_frame_arb_if
//  Description : Bus bundle for crc_frame_arb.
//                s0_* / s1_* : upstream word streams (valid/ready/data/last)
//                m_*         : downstream word stream, m_last flags the CRC
//                              word, m_src names the owning channel
//                frame_cnt   : number of completed frames (wrapping)
//                slave  modport : arbiter side
//                master modport : environment side (sources + sink)
//  Revision    : 1.0 - initial release
// ============================================================================
interface crc_frame_arb_if;
    import crc_pkg::*;

    logic             s0_valid;
    logic             s0_ready;
    logic [CRC_W-1:0] s0_data;
    logic             s0_last;

    logic             s1_valid;
    logic             s1_ready;
    logic [CRC_W-1:0] s1_data;
    logic             s1_last;

    logic             m_valid;
    logic             m_ready;
    logic [CRC_W-1:0] m_data;
    logic             m_last;
    logic             m_src;

    logic [15:0]      frame_cnt;

    modport slave (
        input  s0_valid, s0_data, s0_last,
        input  s1_valid, s1_data, s1_last,
        input  m_ready,
        output s0_ready, s1_ready,
        output m_valid, m_data, m_last, m_src,
        output frame_cnt
    );

    modport master (
        output s0_valid, s0_data, s0_last,
        output s1_valid, s1_data, s1_last,
        output m_ready,
        input  s0_ready, s1_ready,
        input  m_valid, m_data, m_last, m_src,
        input  frame_cnt
    );

endinterface : crc_frame_arb_if
`default_nettype wire

// File: rtl/crc16_ccitt_next.sv
`default_nettype none
// ============================================================================
//  Module      : crc16_ccitt_next
//  Description : Combinational one-step CRC-16 update (x^16+x^12+x^5+1),
//                16 data bits per step, MSB first, no reflection, no final
//                XOR. Data bit i is combined with CRC bit i.
//                crc_in  : current CRC register
//                data_in : 16-bit data word
//                crc_out : CRC after absorbing data_in
//  Revision    : 1.0 - initial release
// ============================================================================
module crc16_ccitt_next
    import crc_pkg::*;
(
    input  wire logic [CRC_W-1:0] crc_in,
    input  wire logic [CRC_W-1:0] data_in,
    output logic      [CRC_W-1:0] crc_out
);

    // With data width equal to CRC width, the update reduces to multiplying
    // (crc ^ data) by x^16 modulo the polynomial.
    logic [CRC_W-1:0] w_x;

    assign w_x = crc_in ^ data_in;

    assign crc_out[0]  = w_x[12] ^ w_x[11] ^ w_x[8]  ^ w_x[4]  ^ w_x[0];
    assign crc_out[1]  = w_x[13] ^ w_x[12] ^ w_x[9]  ^ w_x[5]  ^ w_x[1];
    assign crc_out[2]  = w_x[14] ^ w_x[13] ^ w_x[10] ^ w_x[6]  ^ w_x[2];
    assign crc_out[3]  = w_x[15] ^ w_x[14] ^ w_x[11] ^ w_x[7]  ^ w_x[3];
    assign crc_out[4]  = w_x[15] ^ w_x[12] ^ w_x[8]  ^ w_x[4];
    assign crc_out[5]  = w_x[13] ^ w_x[12] ^ w_x[11] ^ w_x[9]  ^ w_x[8]
                       ^ w_x[5]  ^ w_x[4]  ^ w_x[0];
    assign crc_out[6]  = w_x[14] ^ w_x[13] ^ w_x[12] ^ w_x[10] ^ w_x[9]
                       ^ w_x[6]  ^ w_x[5]  ^ w_x[1];
    assign crc_out[7]  = w_x[15] ^ w_x[14] ^ w_x[13] ^ w_x[11] ^ w_x[10]
                       ^ w_x[7]  ^ w_x[6]  ^ w_x[2];
    assign crc_out[8]  = w_x[15] ^ w_x[14] ^ w_x[12] ^ w_x[11] ^ w_x[8]
                       ^ w_x[7]  ^ w_x[3];
    assign crc_out[9]  = w_x[15] ^ w_x[13] ^ w_x[12] ^ w_x[9]  ^ w_x[8]
                       ^ w_x[4];
    assign crc_out[10] = w_x[14] ^ w_x[13] ^ w_x[10] ^ w_x[9]  ^ w_x[5];
    assign crc_out[11] = w_x[15] ^ w_x[14] ^ w_x[11] ^ w_x[10] ^ w_x[6];
    assign crc_out[12] = w_x[15] ^ w_x[8]  ^ w_x[7]  ^ w_x[4]  ^ w_x[0];
    assign crc_out[13] = w_x[9]  ^ w_x[8]  ^ w_x[5]  ^ w_x[1];
    assign crc_out[14] = w_x[10] ^ w_x[9]  ^ w_x[6]  ^ w_x[2];
    assign crc_out[15] = w_x[11] ^ w_x[10] ^ w_x[7]  ^ w_x[3];

endmodule : crc16_ccitt_next
`default_nettype wire

// File: rtl/crc_frame_arb.sv
`default_nettype none
// ============================================================================
//  Module      : crc_frame_arb
//  Description : Frame-level round-robin arbiter sharing one CRC-16 engine
//                between two upstream word streams. Forwards the granted
//                frame word by word and appends its CRC as a trailing word.
//                clk   : rising-edge clock
//                rst_n : asynchronous active-low reset
//                bus   : crc_frame_arb_if.slave (s0/s1 in, m out, frame_cnt)
//                SEED  : CRC value loaded at the start of every frame
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_frame_arb
    import crc_pkg::*;
#(
    parameter logic [CRC_W-1:0] SEED = CRC_SEED_DEFAULT
)
(
    input  wire logic         clk,
    input  wire logic         rst_n,
    crc_frame_arb_if.slave    bus
);

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_src;
    logic             r_last_grant;
    logic [CRC_W-1:0] r_crc;
    logic             r_m_valid;
    logic [CRC_W-1:0] r_m_data;
    logic             r_m_last;
    logic [15:0]      r_frame_cnt;

    logic             w_slot_free;
    logic             w_grant;
    logic             w_grant_ch;
    logic             w_accept;
    logic             w_emit_crc;
    logic             w_s0_ready;
    logic             w_s1_ready;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic [CRC_W-1:0] w_sel_data;
    logic [CRC_W-1:0] w_crc_next;

    // Output register can take a new word when empty or being drained now.
    assign w_slot_free = !r_m_valid || bus.m_ready;

    // Only the granted channel is ever looked at.
    assign w_sel_valid = r_src ? bus.s1_valid : bus.s0_valid;
    assign w_sel_data  = r_src ? bus.s1_data  : bus.s0_data;
    assign w_sel_last  = r_src ? bus.s1_last  : bus.s0_last;

    crc16_ccitt_next u_crc_next (
        .crc_in  (r_crc),
        .data_in (w_sel_data),
        .crc_out (w_crc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_ch  = 1'b0;
        w_accept    = 1'b0;
        w_emit_crc  = 1'b0;
        w_s0_ready  = 1'b0;
        w_s1_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                // The grant also waits for slot_free so m_src never changes
                // underneath a CRC word still stalled on the output.
                if (w_slot_free && (bus.s0_valid || bus.s1_valid)) begin
                    w_grant     = 1'b1;
                    w_grant_ch  = (bus.s0_valid && bus.s1_valid) ? !r_last_grant
                                                                 : bus.s1_valid;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                w_s0_ready = w_slot_free && !r_src;
                w_s1_ready = w_slot_free &&  r_src;
                w_accept   = w_slot_free && w_sel_valid;
                if (w_accept && w_sel_last) begin
                    w_state_nxt = CRC;
                end
            end
            CRC: begin
                if (w_slot_free) begin
                    w_emit_crc  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src        <= 1'b0;
            r_last_grant <= 1'b1;
            r_crc        <= SEED;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_last     <= 1'b0;
            r_frame_cnt  <= 16'd0;
        end else begin
            if (w_grant) begin
                r_src <= w_grant_ch;
                r_crc <= SEED;
            end
            if (w_accept) begin
                r_m_data  <= w_sel_data;
                r_m_last  <= 1'b0;
                r_m_valid <= 1'b1;
                r_crc     <= w_crc_next;
            end else if (w_emit_crc) begin
                r_m_data     <= r_crc;
                r_m_last     <= 1'b1;
                r_m_valid    <= 1'b1;
                r_last_grant <= r_src;
                r_frame_cnt  <= r_frame_cnt + 16'd1;
            end else if (w_slot_free) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign bus.s0_ready  = w_s0_ready;
    assign bus.s1_ready  = w_s1_ready;
    assign bus.m_valid   = r_m_valid;
    assign bus.m_data    = r_m_data;
    assign bus.m_last    = r_m_last;
    assign bus.m_src     = r_src;
    assign bus.frame_cnt = r_frame_cnt;

endmodule : crc_frame_arb
`default_nettype wire

// File: tb/tb_crc_frame_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc_frame_arb
//  Description : Self-checking bench for crc_frame_arb. Each sent frame
//                pushes its words and reference CRC into a per-channel
//                queue; a monitor pops and compares on every output
//                transfer. Scenario tasks add their own inline checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_frame_arb;

    localparam int          TMO   = 200;
    localparam logic [15:0] C_SEED = 16'hFFFF;

    logic clk;
    logic rst_n;

    crc_frame_arb_if bus();

    crc_frame_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          assertions = 0;
    int          failures   = 0;
    int          exp_fc     = 0;
    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic        src_log[$];
    logic [15:0] last_crc_word = 16'h0;
    bit          sb_en = 1'b1;
    logic        prev_stall = 1'b0;
    logic [15:0] pd;
    logic        pl;
    logic        ps;

    // Bit-serial reference: MSB first, feedback = crc[15] ^ data bit.
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 15; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    // Scoreboard monitor plus hold-while-stalled check.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    assertions++;
                    if (bus.m_valid !== 1'b1 || bus.m_data !== pd || bus.m_last !== pl || bus.m_src !== ps) begin
                        failures++;
                        $display("FAIL hold_stall: got v=%b d=%h l=%b s=%b, required v=1 d=%h l=%b s=%b",
                                 bus.m_valid, bus.m_data, bus.m_last, bus.m_src, pd, pl, ps);
                    end
                end
                if (bus.m_valid && bus.m_ready) begin
                    if (sb_en) begin
                        assertions++;
                        if ((bus.m_src ? q1.size() : q0.size()) == 0) begin
                            failures++;
                            $display("FAIL sb_unexpected: got d=%h l=%b on src %b, required no word",
                                     bus.m_data, bus.m_last, bus.m_src);
                        end else begin
                            e = bus.m_src ? q1.pop_front() : q0.pop_front();
                            if (bus.m_data !== e[15:0] || bus.m_last !== e[16]) begin
                                failures++;
                                $display("FAIL sb_word src%0d: got d=%h l=%b, required d=%h l=%b",
                                         bus.m_src, bus.m_data, bus.m_last, e[15:0], e[16]);
                            end
                        end
                    end
                    if (bus.m_last) begin
                        last_crc_word = bus.m_data;
                        src_log.push_back(bus.m_src);
                    end
                end
                prev_stall = bus.m_valid && !bus.m_ready;
                pd = bus.m_data;
                pl = bus.m_last;
                ps = bus.m_src;
            end
        end
    end

    task automatic drive(input int ch, input logic v, input logic [15:0] d, input logic l);
        if (ch == 0) begin
            bus.s0_valid = v; bus.s0_data = d; bus.s0_last = l;
        end else begin
            bus.s1_valid = v; bus.s1_data = d; bus.s1_last = l;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the last word is taken.
    // Leaves valid asserted so frames can follow back to back.
    task automatic send_frame(input int ch, input int n, input logic [15:0] first, input bit rnd);
        logic [15:0] w [0:31];
        logic [15:0] c;
        logic        rdy;
        int          cnt;
        c = C_SEED;
        for (int k = 0; k < n; k++) begin
            w[k] = rnd ? 16'($urandom) : first + 16'(k) * 16'h1111;
            c    = crc_model(c, w[k]);
            if (ch == 0) q0.push_back({1'b0, w[k]}); else q1.push_back({1'b0, w[k]});
        end
        if (ch == 0) q0.push_back({1'b1, c}); else q1.push_back({1'b1, c});
        exp_fc++;
        for (int k = 0; k < n; k++) begin
            drive(ch, 1'b1, w[k], k == n - 1);
            cnt = 0;
            rdy = 1'b0;
            while (!rdy && cnt < TMO) begin
                @(negedge clk);
                rdy = (ch == 0) ? bus.s0_ready : bus.s1_ready;
                cnt++;
            end
            if (!rdy) begin
                assertions++;
                failures++;
                $display("FAIL handshake_timeout ch%0d word %0d: ready=0 after %0d cycles, required 1", ch, k, cnt);
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int cnt;
        cnt = 0;
        while ((q0.size() != 0 || q1.size() != 0) && cnt < TMO) begin
            @(negedge clk);
            cnt++;
        end
        assertions++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d/%0d words pending, required 0/0", q0.size(), q1.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 1'b0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 1'b0);
        bus.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        src_log.delete();
        exp_fc = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        assertions++;
        if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b, required 0", bus.m_valid); end
        assertions++;
        if (bus.m_data !== 16'h0) begin failures++; $display("FAIL reset_m_data: got %h, required 0000", bus.m_data); end
        assertions++;
        if (bus.m_last !== 1'b0 || bus.m_src !== 1'b0) begin
            failures++; $display("FAIL reset_last_src: got last=%b src=%b, required 0 0", bus.m_last, bus.m_src);
        end
        assertions++;
        if (bus.frame_cnt !== 16'h0) begin failures++; $display("FAIL reset_frame_cnt: got %h, required 0000", bus.frame_cnt); end
        assertions++;
        if (bus.s0_ready !== 1'b0 || bus.s1_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready: got %b%b, required 00", bus.s0_ready, bus.s1_ready);
        end
    endtask

    task automatic test_single(input int ch, input logic [15:0] word, input logic [15:0] crc_exp);
        send_frame(ch, 1, word, 1'b0);
        drive(ch, 1'b0, 16'h0, 1'b0);
        wait_drain();
        assertions++;
        if (last_crc_word !== crc_exp) begin
            failures++; $display("FAIL single_crc ch%0d: got %h, required %h", ch, last_crc_word, crc_exp);
        end
        assertions++;
        if (src_log.size() == 0 || src_log[src_log.size()-1] !== 1'(ch)) begin
            failures++; $display("FAIL single_src ch%0d: got log size %0d, required last src %0d", ch, src_log.size(), ch);
        end
        assertions++;
        if (bus.frame_cnt !== 16'(exp_fc)) begin
            failures++; $display("FAIL single_frame_cnt: got %0d, required %0d", bus.frame_cnt, exp_fc);
        end
    endtask

    task automatic test_burst();
        for (int f = 0; f < 20; f++) send_frame(1, 1, 16'h0, 1'b1);
        drive(1, 1'b0, 16'h0, 1'b0);
        wait_drain();
        assertions++;
        if (bus.frame_cnt !== 16'(exp_fc)) begin
            failures++; $display("FAIL burst_frame_cnt: got %0d, required %0d", bus.frame_cnt, exp_fc);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_src [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int   lasts;
        int   gap_state;
        int   cyc;
        do_reset();
        lasts = 0;
        gap_state = 0;
        cyc = 0;
        fork
            begin
                for (int f = 0; f < 2; f++) send_frame(0, 3, 16'h0, 1'b1);
                drive(0, 1'b0, 16'h0, 1'b0);
            end
            begin
                for (int f = 0; f < 2; f++) send_frame(1, 3, 16'h0, 1'b1);
                drive(1, 1'b0, 16'h0, 1'b0);
            end
            begin
                while (lasts < 4 && cyc < 400) begin
                    @(negedge clk);
                    cyc++;
                    if (gap_state == 1) begin
                        assertions++;
                        if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap: got m_valid=%b, required 0", bus.m_valid); end
                        gap_state = 2;
                    end else if (gap_state == 2) begin
                        assertions++;
                        if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL b2b_resume: got m_valid=%b, required 1", bus.m_valid); end
                        gap_state = 0;
                    end
                    if (bus.s0_ready) begin
                        assertions++;
                        if (bus.s1_ready !== 1'b0 || bus.m_src !== 1'b0) begin
                            failures++; $display("FAIL b2b_ready0: got s1_ready=%b src=%b, required 0 0", bus.s1_ready, bus.m_src);
                        end
                    end
                    if (bus.s1_ready) begin
                        assertions++;
                        if (bus.s0_ready !== 1'b0 || bus.m_src !== 1'b1) begin
                            failures++; $display("FAIL b2b_ready1: got s0_ready=%b src=%b, required 0 1", bus.s0_ready, bus.m_src);
                        end
                    end
                    if (bus.m_valid && bus.m_ready && bus.m_last) begin
                        lasts++;
                        if (lasts < 4) gap_state = 1;
                    end
                end
                assertions++;
                if (lasts != 4) begin failures++; $display("FAIL b2b_frames: got %0d frames, required 4", lasts); end
            end
        join
        wait_drain();
        for (int i = 0; i < 4; i++) begin
            assertions++;
            if (i >= src_log.size() || src_log[i] !== exp_src[i]) begin
                failures++; $display("FAIL b2b_grant_order[%0d]: got log size %0d, required src %b", i, src_log.size(), exp_src[i]);
            end
        end
    endtask

    task automatic test_mready_random();
        bit done;
        done = 1'b0;
        fork
            begin
                send_frame(0, 8, 16'hA5A5, 1'b0);
                drive(0, 1'b0, 16'h0, 1'b0);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.m_ready = 1'($urandom);
                end
            end
        join
        bus.m_ready = 1'b1;
        wait_drain();
        assertions++;
        if (bus.frame_cnt !== 16'(exp_fc)) begin
            failures++; $display("FAIL mready_frame_cnt: got %0d, required %0d", bus.frame_cnt, exp_fc);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] exp_crc;
        sb_en = 1'b0;
        bus.m_ready = 1'b1;
        drive(0, 1'b1, 16'h1000, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        assertions++;
        if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL async_m_valid: got %b, required 0", bus.m_valid); end
        assertions++;
        if (bus.frame_cnt !== 16'h0) begin failures++; $display("FAIL async_frame_cnt: got %h, required 0000", bus.frame_cnt); end
        assertions++;
        if (bus.s0_ready !== 1'b0) begin failures++; $display("FAIL async_ready: got %b, required 0", bus.s0_ready); end
        drive(0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        src_log.delete();
        exp_fc = 0;
        sb_en = 1'b1;
        @(posedge clk);
        #1;
        exp_crc = crc_model(C_SEED, 16'h1234);
        send_frame(0, 1, 16'h1234, 1'b0);
        drive(0, 1'b0, 16'h0, 1'b0);
        wait_drain();
        assertions++;
        if (last_crc_word !== exp_crc) begin
            failures++; $display("FAIL async_post_crc: got %h, required %h", last_crc_word, exp_crc);
        end
        assertions++;
        if (bus.frame_cnt !== 16'd1) begin failures++; $display("FAIL async_post_cnt: got %0d, required 1", bus.frame_cnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 1'b0);
        bus.m_ready = 1'b1;
        do_reset();
        test_reset();
        test_single(0, 16'h0000, 16'h1D0F);
        test_single(1, 16'hFFFF, 16'h0000);
        test_burst();
        test_back_to_back();
        test_mready_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule : tb_crc_frame_arb
`default_nettype wire
